// File: rtl/core_pkg.sv
// core_pkg: shared ALU opcode constants, LSU FSM encoding and opcode class helpers.
package core_pkg;
  localparam logic [5:0] ALUOP_LW       = 6'd32;
  localparam logic [5:0] ALUOP_SW       = 6'd35;
  localparam logic [5:0] ALUOP_AMOSWAP  = 6'd36;
  localparam logic [5:0] ALUOP_LR       = 6'd37;
  localparam logic [5:0] ALUOP_SC       = 6'd38;
  localparam logic [5:0] ALUOP_BR_FIRST = 6'd40;
  localparam logic [5:0] ALUOP_BR_LAST  = 6'd45;
  typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} lsu_state_t;
  function automatic logic is_mem(input logic [5:0] op);
    return op inside {ALUOP_LW, ALUOP_SW, ALUOP_AMOSWAP, ALUOP_LR, ALUOP_SC};
  endfunction
  function automatic logic is_branch(input logic [5:0] op);
    return op >= ALUOP_BR_FIRST && op <= ALUOP_BR_LAST;
  endfunction
endpackage

// File: rtl/lsu_resv.sv
// lsu_resv: single LR/SC reservation, a valid bit plus a word-address tag.
module lsu_resv #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set,
  input  logic              clr,
  input  logic [ADDR_W-3:0] set_tag,
  input  logic [ADDR_W-3:0] cmp_tag,
  output logic              hit
);
  logic              valid;
  logic [ADDR_W-3:0] tag;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
    end else if (set) begin
      valid <= 1'b1;
      tag   <= set_tag;
    end else if (clr) begin
      valid <= 1'b0;
    end
  assign hit = valid && tag == cmp_tag;
endmodule

// File: rtl/lsu_amo.sv
// lsu_amo: memory-stage load/store/LR/SC/AMOSWAP unit with single-stage pass-through writeback.
module lsu_amo
  import core_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [5:0]        ex_aluop,
  input  logic [DATA_W-1:0] ex_aluout,
  input  logic [DATA_W-1:0] ex_rs2_data,
  input  logic [4:0]        ex_rd,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              misalign
);
  lsu_state_t        state, state_d;
  logic [5:0]        op, op_d;
  logic [ADDR_W-3:0] wa, wa_d, cmp_tag;
  logic [DATA_W-1:0] wdata, wdata_d, rdata, rdata_d, wb_data_d;
  logic [4:0]        rd, rd_d, wb_rd_d;
  logic              wb_valid_d, misalign_d, resv_set, resv_clr, resv_hit;
  assign ex_ready  = state == IDLE;
  assign mem_addr  = {wa, 2'b00};
  assign mem_wdata = wdata;
  // SC checks the incoming address at acceptance; write grants check the latched one.
  assign cmp_tag   = state == IDLE ? ex_aluout[ADDR_W-1:2] : wa;
  lsu_resv #(.ADDR_W(ADDR_W)) u_resv (
    .clk(clk), .rst(rst), .set(resv_set), .clr(resv_clr),
    .set_tag(wa), .cmp_tag(cmp_tag), .hit(resv_hit)
  );
  always_comb begin
    state_d    = state;
    op_d       = op;
    wa_d       = wa;
    wdata_d    = wdata;
    rd_d       = rd;
    rdata_d    = rdata;
    wb_valid_d = 1'b0;
    wb_rd_d    = ex_rd;
    wb_data_d  = ex_aluout;
    misalign_d = 1'b0;
    resv_set   = 1'b0;
    resv_clr   = 1'b0;
    case (state)
      IDLE: if (ex_valid) begin
        if (is_mem(ex_aluop) && ex_aluout[1:0] != 2'b00) misalign_d = 1'b1;
        else begin
          op_d    = ex_aluop;
          wa_d    = ex_aluout[ADDR_W-1:2];
          wdata_d = ex_rs2_data;
          rd_d    = ex_rd;
          if (ex_aluop inside {ALUOP_LW, ALUOP_LR, ALUOP_AMOSWAP}) state_d = RD_REQ;
          else if (ex_aluop == ALUOP_SW || (ex_aluop == ALUOP_SC && resv_hit)) state_d = WR_REQ;
          resv_clr   = ex_aluop == ALUOP_SC;
          wb_valid_d = (!is_mem(ex_aluop) && !is_branch(ex_aluop)) || (ex_aluop == ALUOP_SC && !resv_hit);
          wb_data_d  = ex_aluop == ALUOP_SC ? DATA_W'(1) : ex_aluout;
        end
      end
      RD_REQ: if (mem_gnt) state_d = RD_WAIT;
      RD_WAIT: if (mem_rvalid) begin
        rdata_d    = mem_rdata;
        resv_set   = op == ALUOP_LR;
        state_d    = op == ALUOP_AMOSWAP ? WR_REQ : IDLE;
        wb_valid_d = op != ALUOP_AMOSWAP;
        wb_rd_d    = rd;
        wb_data_d  = mem_rdata;
      end
      WR_REQ: if (mem_gnt) begin
        state_d    = IDLE;
        resv_clr   = resv_hit;
        wb_valid_d = op == ALUOP_SC || op == ALUOP_AMOSWAP;
        wb_rd_d    = rd;
        wb_data_d  = op == ALUOP_SC ? '0 : rdata;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      op       <= '0;
      wa       <= '0;
      wdata    <= '0;
      rd       <= '0;
      rdata    <= '0;
      mem_req  <= 1'b0;
      mem_we   <= 1'b0;
      wb_valid <= 1'b0;
      wb_rd    <= '0;
      wb_data  <= '0;
      misalign <= 1'b0;
    end else begin
      state    <= state_d;
      op       <= op_d;
      wa       <= wa_d;
      wdata    <= wdata_d;
      rd       <= rd_d;
      rdata    <= rdata_d;
      mem_req  <= state_d == RD_REQ || state_d == WR_REQ;
      mem_we   <= state_d == WR_REQ;
      wb_valid <= wb_valid_d;
      misalign <= misalign_d;
      if (wb_valid_d) begin
        wb_rd   <= wb_rd_d;
        wb_data <= wb_data_d;
      end
    end
endmodule

// File: doc/lsu_amo.md
# lsu_amo

Memory-stage load/store/atomic unit that consumes execute-stage ALU results (address in the ALU result, store data in the rs2 data path) and drives the data-memory request/response port. It handles LW, SW, LR.W, SC.W and AMOSWAP.W, including the LR/SC reservation. It passes all other ALU results through to writeback with one register stage, and sits between the execute stage and the register-file writeback.

## Interface
- `ADDR_W`, default 32: address width.
- `DATA_W`, default 32: data width.
- `clk` in 1: core clock, all state on rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `ex_valid` in 1: execute result valid.
- `ex_ready` out 1: unit can accept; high only in IDLE.
- `ex_aluop` in 6: ALU opcode of the instruction.
- `ex_aluout` in 32: ALU result; memory address for memory ops.
- `ex_rs2_data` in 32: store / swap / SC data.
- `ex_rd` in 5: destination register.
- `mem_req` out 1: memory request, registered.
- `mem_we` out 1: 1 = write.
- `mem_addr` out 32: word address, bits [1:0] = 0.
- `mem_wdata` out 32: write data.
- `mem_gnt` in 1: request accepted this cycle.
- `mem_rvalid` in 1: read data valid; arrives at least 1 cycle after the read grant.
- `mem_rdata` in 32: read data.
- `wb_valid` out 1: one-cycle writeback pulse.
- `wb_rd` out 5: writeback register.
- `wb_data` out 32: writeback data.
- `misalign` out 1: one-cycle pulse on a misaligned memory op.

## Operation
- **Op classes:**
  - 32 LW, 35 SW, 36 AMOSWAP.W, 37 LR.W, 38 SC.W are memory ops.
  - 40–45 (branches) produce no writeback.
  - Every other opcode is pass-through: `wb_data = ex_aluout`.
- **Acceptance:** handshake `ex_valid & ex_ready`. Inputs are latched into op/addr/wdata/rd registers on acceptance.
- **Misalignment:** a memory op with `addr[1:0] != 0` pulses `misalign` the next cycle. It makes no memory access, produces no writeback, leaves the reservation unchanged, and the unit stays in IDLE.
- **FSM states:** IDLE, RD_REQ, RD_WAIT, WR_REQ.
- **Transitions:**
  - IDLE → RD_REQ on LW, LR.W or AMOSWAP.W.
  - IDLE → WR_REQ on SW, or on SC.W with the reservation hit.
  - IDLE → IDLE otherwise; a failed SC.W writes back next cycle.
  - RD_REQ: `mem_req=1`, `mem_we=0`; goes to RD_WAIT on `mem_gnt`.
  - RD_WAIT: on `mem_rvalid`, latch `rdata`. LW/LR.W then write back and return to IDLE. AMOSWAP.W holds `rdata` for writeback and goes to WR_REQ.
  - WR_REQ: `mem_req=1`, `mem_we=1`, `mem_wdata = rs2 data`. On `mem_gnt`, return to IDLE; SC.W and AMOSWAP.W write back in the following cycle.
- **Reservation:** one valid bit plus a word-address tag `[31:2]`.
  - LR.W sets both when its read completes.
  - SC.W: on a hit (valid and tag match), store and write back 0. On a miss, no store and write back 1. The reservation is cleared in both cases.
  - A granted SW or AMOSWAP.W write to the tagged word clears the reservation.
- **Writeback value:** AMOSWAP.W writes back the old memory value.
- **Register 0:** `rd = 0` is still written back; the register file discards it.

## Timing
- **Reset values:** `ex_ready=1`; `mem_req=0`, `mem_we=0`, `mem_addr=0`, `mem_wdata=0`; `wb_valid=0`, `wb_rd=0`, `wb_data=0`; `misalign=0`; reservation invalid; state IDLE.
- **Pass-through:** accepted in cycle N, `wb_valid` in N+1. Back-to-back pass-through ops sustain one per cycle.
- **LW, zero-wait grant, `rvalid` one cycle after grant:** accept N, `mem_req` N+1, `rvalid` N+2, `wb_valid` N+3.
- **SW:** accept N, `mem_req`/`mem_we` N+1; the unit is ready again in N+2.
- **AMOSWAP.W:** read as for LW, then the write request begins in the cycle after `rvalid`. `wb_valid` comes one cycle after the write grant.
- **Request stability:** `mem_req` and all `mem_*` outputs hold stable until `mem_gnt`.
- **Stray responses:** a `mem_rvalid` outside RD_WAIT is ignored.
- **Reset mid-operation:** `rst` asserted in any state immediately drops `mem_req`, clears the reservation and returns to IDLE. A pending `rvalid` after reset is ignored.

## Structure
- **Shared package `core_pkg`:**
  - aluop constants `ALUOP_LW`=32, `ALUOP_SW`=35, `ALUOP_AMOSWAP`=36, `ALUOP_LR`=37, `ALUOP_SC`=38, `ALUOP_BR_FIRST`=40, `ALUOP_BR_LAST`=45;
  - the FSM state encoding `lsu_state_t`.
- **Sub-module `lsu_resv`:** the reservation register with set/clear/compare ports.

## Test plan
- **Pass-through:** aluop 0, `aluout = 0x0000_0010`, `rd = 5` → `wb_valid` next cycle with `rd=5`, `data=0x10`; no `mem_req`.
- **LW:** addr `0x100`, memory returns `0xDEADBEEF`, `gnt` delayed 2 cycles → `mem_addr` held at `0x100` until grant; `wb_data=0xDEADBEEF` one cycle after `rvalid`.
- **LR/SC hit:** LR.W to `0x200`, then SC.W to `0x200` with data `0x55` → write of `0x55` to `0x200`, `wb_data=0`.
- **LR/SC miss:** LR.W to `0x200`, then SW to `0x200`, then SC.W to `0x200` → no SC write, `wb_data=1`.
- **AMOSWAP:** memory `[0x300]=7`, rs2 `=9` → read then write of 9 to `0x300`; `wb_data=7`.
- **Misaligned and reset:** SW to `0x102` → `misalign` pulse, no `mem_req`. Then `rst` asserted while in RD_WAIT → IDLE, `ex_ready=1`, the late `rvalid` is ignored and no writeback occurs.
